// File: rtl/pon_tx_queue_scheduler_if.sv
// Signal bundle between the PON TX queue scheduler, the per-queue FWFT TX FIFOs and the GT TX mux.
// master = scheduler side, slave = FIFO/mux side.
interface pon_tx_queue_scheduler_if #(
  parameter int NUM_Q   = 4,
  parameter int LEVEL_W = 12,
  parameter int LEN_W   = 16
);
  localparam int SEL_W = $clog2(NUM_Q);

  logic                     gt_tx_active;
  logic [NUM_Q*LEVEL_W-1:0] q_level;
  logic [NUM_Q-1:0]         q_tvalid;
  logic [NUM_Q-1:0]         q_tlast;
  logic                     tx_tready;
  logic [NUM_Q-1:0]         q_rd_en;
  logic [SEL_W-1:0]         sel_q;
  logic                     busy;
  logic                     frame_done;
  logic [LEN_W-1:0]         frame_len;

  modport master (
    input  gt_tx_active, q_level, q_tvalid, q_tlast, tx_tready,
    output q_rd_en, sel_q, busy, frame_done, frame_len
  );

  modport slave (
    output gt_tx_active, q_level, q_tvalid, q_tlast, tx_tready,
    input  q_rd_en, sel_q, busy, frame_done, frame_len
  );
endinterface

// File: rtl/pon_tx_queue_scheduler.sv
// Frame-granular scheduler sharing the PON upstream GT TX path between NUM_Q FWFT queue FIFOs.
// Define PON_SCHED_STRICT_PRIO_EN for fixed priority (queue 0 highest); default is round-robin.
module pon_tx_queue_scheduler #(
  parameter int NUM_Q     = 4,
  parameter int LEVEL_W   = 12,
  parameter int MIN_LEVEL = 64,
  parameter int IDLE_GAP  = 2,
  parameter int LEN_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  pon_tx_queue_scheduler_if.master        sched_if
);
  localparam int                   SEL_W   = $clog2(NUM_Q);
  localparam int                   GAP_W   = 4;
  localparam logic [SEL_W-1:0]     LAST_Q  = SEL_W'(NUM_Q - 1);
  localparam logic [LEVEL_W-1:0]   MIN_LVL = LEVEL_W'(MIN_LEVEL);
  localparam logic [GAP_W-1:0]     GAP_END = GAP_W'(IDLE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_READ, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   grant_idx_q, grant_idx_d;
  logic [SEL_W-1:0]   last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               frame_done_q, frame_done_d;

  logic [NUM_Q-1:0]   eligible;
  logic [NUM_Q-1:0]   rd_en;
  logic               hit;
  logic [SEL_W-1:0]   pick;
  logic               xfer;
  logic [LEN_W-1:0]   cnt_inc;

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i] = (sched_if.q_level[i*LEVEL_W +: LEVEL_W] >= MIN_LVL) && sched_if.q_tvalid[i];
    end
  end

  // NOTE: every signal written in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
`ifdef PON_SCHED_STRICT_PRIO_EN
    for (int i = 0; i < NUM_Q; i++) begin
      if (!hit && eligible[i]) begin
        hit  = 1'b1;
        pick = SEL_W'(i);
      end
    end
`else
    // First pass: indices above last_grant; second pass wraps round to 0..last_grant.
    for (int i = 0; i < NUM_Q; i++) begin
      if (!hit && eligible[i] && (SEL_W'(i) > last_grant_q)) begin
        hit  = 1'b1;
        pick = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_Q; i++) begin
      if (!hit && eligible[i] && (SEL_W'(i) <= last_grant_q)) begin
        hit  = 1'b1;
        pick = SEL_W'(i);
      end
    end
`endif
  end

  always_comb begin
    rd_en = '0;
    if (state_q == S_READ) begin
      rd_en[grant_idx_q] = sched_if.tx_tready & sched_if.q_tvalid[grant_idx_q];
    end
  end

  assign xfer    = |rd_en;
  assign cnt_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    frame_len_d  = frame_len_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sched_if.gt_tx_active) state_d = S_ARB;
      end
      S_ARB: begin
        if (!sched_if.gt_tx_active) begin
          state_d = S_IDLE;
        end else if (hit) begin
          grant_idx_d  = pick;
          last_grant_d = pick;
          word_cnt_d   = '0;
          state_d      = S_READ;
        end
      end
      S_READ: begin
        // The window closing mid-frame is deliberately ignored: a frame always runs to TLAST.
        if (xfer) begin
          word_cnt_d = cnt_inc;
          if (sched_if.q_tlast[grant_idx_q]) begin
            frame_done_d = 1'b1;
            frame_len_d  = cnt_inc;
            gap_cnt_d    = '0;
            if (IDLE_GAP == 0) state_d = sched_if.gt_tx_active ? S_ARB : S_IDLE;
            else               state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_END) state_d = sched_if.gt_tx_active ? S_ARB : S_IDLE;
        else                      gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_Q;
      word_cnt_q   <= '0;
      frame_len_q  <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      frame_len_q  <= frame_len_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sched_if.q_rd_en    = rd_en;
  assign sched_if.sel_q      = grant_idx_q;
  assign sched_if.busy       = (state_q == S_READ);
  assign sched_if.frame_done = frame_done_q;
  assign sched_if.frame_len  = frame_len_q;
endmodule

// File: tb/tb_pon_tx_queue_scheduler.sv
// Bench for pon_tx_queue_scheduler: FIFO models feed the DUT, a frame-level model predicts
// grants, read enables and frame completions; table vectors and directed sequences on top.
module tb_pon_tx_queue_scheduler;
  localparam int NUM_Q     = 4;
  localparam int LEVEL_W   = 12;
  localparam int MIN_LEVEL = 64;
  localparam int IDLE_GAP  = 2;
  localparam int LEN_W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pon_tx_queue_scheduler_if #(.NUM_Q(NUM_Q), .LEVEL_W(LEVEL_W), .LEN_W(LEN_W)) bus ();

  pon_tx_queue_scheduler #(
    .NUM_Q(NUM_Q), .LEVEL_W(LEVEL_W), .MIN_LEVEL(MIN_LEVEL), .IDLE_GAP(IDLE_GAP), .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit fifo [NUM_Q][$];
  int bias [NUM_Q];
  bit model_drive = 1'b1;
  bit rand_mode   = 1'b0;
  bit toggle_mode = 1'b0;
  bit gt_r        = 1'b1;
  bit rst_edge;
  int step_no     = 0;

  int               m_last = NUM_Q - 1;
  int               m_sel  = 0;
  int               m_cnt  = 0;
  bit               m_pend = 1'b0;
  int               m_pend_len = 0;
  bit               busy_prev = 1'b0;
  logic [NUM_Q-1:0] prev_elig = '0;
  int               xfer_q = -1;
  int               xfer_total = 0;
  int               last_tlast_step = -1;
  int               grant_log[$];
  int               done_log[$];
  int               gap_log[$];

  typedef struct {
    logic [NUM_Q*LEVEL_W-1:0] lvl;
    logic [NUM_Q-1:0]         vld;
    bit                       gt;
    int                       exp_sel;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, exp_v, step_no);
    end
  endtask

  // Reference arbitration: round-robin from the queue after the last grant, or lowest index.
  function automatic int ref_pick(input logic [NUM_Q-1:0] el, input int last);
`ifdef PON_SCHED_STRICT_PRIO_EN
    for (int c = 0; c < NUM_Q; c++) if (el[c]) return c;
`else
    for (int k = 1; k <= NUM_Q; k++) if (el[(last + k) % NUM_Q]) return (last + k) % NUM_Q;
`endif
    return -1;
  endfunction

  function automatic logic [NUM_Q-1:0] cur_elig();
    logic [NUM_Q-1:0] el;
    for (int i = 0; i < NUM_Q; i++)
      el[i] = (int'(bus.q_level[i*LEVEL_W +: LEVEL_W]) >= MIN_LEVEL) && bus.q_tvalid[i];
    return el;
  endfunction

  task automatic drive_inputs();
    int sz;
    int lv;
    bus.gt_tx_active = gt_r;
    if (rand_mode)        bus.tx_tready = 1'($urandom_range(0, 1));
    else if (toggle_mode) bus.tx_tready = ~bus.tx_tready;
    else                  bus.tx_tready = 1'b1;
    if (model_drive) begin
      for (int i = 0; i < NUM_Q; i++) begin
        sz = fifo[i].size();
        lv = sz + bias[i];
        if (lv > 4095) lv = 4095;
        bus.q_level[i*LEVEL_W +: LEVEL_W] = LEVEL_W'(lv);
        bus.q_tvalid[i] = (sz > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
        bus.q_tlast[i]  = (sz > 0) ? fifo[i][0] : 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [NUM_Q-1:0] rd;
    logic [NUM_Q-1:0] exp_rd;
    int sel;
    int exp_g;
    rd  = bus.q_rd_en;
    sel = int'(bus.sel_q);
    if (rst_edge) begin
      check("reset_q_rd_en", int'(rd), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_frame_done", int'(bus.frame_done), 0);
      check("reset_sel_q", sel, 0);
      check("reset_frame_len", int'(bus.frame_len), 0);
      m_last = NUM_Q - 1;
      m_pend = 1'b0;
      m_cnt  = 0;
      busy_prev = 1'b0;
      last_tlast_step = -1;
      xfer_q = -1;
    end else begin
      check("rd_en_onehot", int'($countones(rd) <= 1), 1);
      exp_rd = '0;
      if (bus.busy) exp_rd[sel] = bus.tx_tready & bus.q_tvalid[sel];
      check("rd_en_rule", int'(rd), int'(exp_rd));
      check("frame_done", int'(bus.frame_done), int'(m_pend));
      if (m_pend) check("frame_len", int'(bus.frame_len), m_pend_len);
      if (bus.frame_done) done_log.push_back(int'(bus.frame_len));
      m_pend = 1'b0;
      if (bus.busy && !busy_prev) begin
        exp_g = ref_pick(prev_elig, m_last);
        check("grant_sel", sel, exp_g);
        m_last = sel;
        m_sel  = sel;
        m_cnt  = 0;
        grant_log.push_back(sel);
        if (last_tlast_step >= 0) gap_log.push_back(step_no - last_tlast_step);
      end else if (bus.busy) begin
        check("sel_stable", sel, m_sel);
      end
      if (bus.busy && rd[sel]) begin
        m_cnt++;
        xfer_total++;
        if (bus.q_tlast[sel]) begin
          m_pend = 1'b1;
          m_pend_len = (m_cnt > 65535) ? 65535 : m_cnt;
          last_tlast_step = step_no;
        end
      end
      xfer_q = -1;
      for (int i = 0; i < NUM_Q; i++) if (rd[i]) xfer_q = i;
      busy_prev = bus.busy;
    end
    prev_elig = cur_elig();
  endtask

  // One clock: pop what was read at this edge, drive new inputs, then sample outputs.
  task automatic step();
    @(posedge clk);
    rst_edge = rst;
    if (model_drive && xfer_q >= 0 && fifo[xfer_q].size() > 0) void'(fifo[xfer_q].pop_front());
    #1;
    drive_inputs();
    #1;
    monitor();
    step_no++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    grant_log.delete();
    done_log.delete();
    gap_log.delete();
    xfer_total = 0;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NUM_Q; i++) begin
      fifo[i].delete();
      bias[i] = 0;
    end
  endtask

  task automatic load(input int q, input int nframes, input int len);
    for (int f = 0; f < nframes; f++)
      for (int w = 0; w < len; w++) fifo[q].push_back(w == len - 1);
  endtask

  function automatic int grant_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n0;
    int exp_b;
    int exp_e;
    vecs[0] = '{{12'd64, 12'd64, 12'd64, 12'd64}, 4'b1111, 1'b1, 0};
    vecs[1] = '{{12'd64, 12'd0, 12'd63, 12'd0}, 4'b1111, 1'b1, 3};
    vecs[2] = '{{12'd64, 12'd0, 12'd64, 12'd0}, 4'b1111, 1'b1, 1};
    vecs[3] = '{{12'd64, 12'd64, 12'd64, 12'd64}, 4'b0000, 1'b1, -1};
    vecs[4] = '{{12'd4095, 12'd4095, 12'd4095, 12'd4095}, 4'b0100, 1'b1, 2};
    vecs[5] = '{{12'd63, 12'd63, 12'd63, 12'd63}, 4'b1111, 1'b1, -1};
    vecs[6] = '{{12'd65, 12'd100, 12'd0, 12'd64}, 4'b1100, 1'b1, 2};
    vecs[7] = '{{12'd64, 12'd64, 12'd64, 12'd64}, 4'b1111, 1'b0, -1};

    // Reset with every queue eligible, then IDLE -> ARB -> first read.
    clear_fifos();
    for (int i = 0; i < NUM_Q; i++) begin
      load(i, 1, 4);
      bias[i] = 64;
    end
    gt_r = 1'b1;
    do_reset(3);
    step();
    check("A_rd_en_in_arb", int'(bus.q_rd_en), 0);
    step();
    check("A_first_rd_en", int'(bus.q_rd_en), 1);
    check("A_first_sel", int'(bus.sel_q), 0);

    // First grant after reset for directly driven level/valid patterns.
    model_drive = 1'b0;
    foreach (vecs[v]) begin
      do_reset(2);
      bus.q_level  = vecs[v].lvl;
      bus.q_tvalid = vecs[v].vld;
      bus.q_tlast  = '1;
      gt_r         = vecs[v].gt;
      for (int c = 0; c < 6 && grant_log.size() == 0; c++) step();
      got = grant_at(0);
      check($sformatf("T%0d_first_grant", v), got, vecs[v].exp_sel);
    end
    model_drive = 1'b1;
    gt_r = 1'b1;

    // Queues 0 and 2, three 10-word frames each.
    clear_fifos();
    load(0, 3, 10);
    load(2, 3, 10);
    bias[0] = 64;
    bias[2] = 64;
    do_reset(2);
    for (int c = 0; c < 400 && done_log.size() < 6; c++) step();
    check("B_done_count", done_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
`ifdef PON_SCHED_STRICT_PRIO_EN
      exp_b = (i < 3) ? 0 : 2;
`else
      exp_b = (i % 2 == 0) ? 0 : 2;
`endif
      check($sformatf("B_grant%0d", i), grant_at(i), exp_b);
      check($sformatf("B_len%0d", i), (i < done_log.size()) ? done_log[i] : -1, 10);
    end
    check("B_gap_count", gap_log.size(), 5);
    foreach (gap_log[i]) check($sformatf("B_gap%0d", i), gap_log[i], IDLE_GAP + 2);

    // 20-word frame with tx_tready toggling every cycle.
    clear_fifos();
    load(1, 1, 20);
    bias[1] = 64;
    do_reset(2);
    toggle_mode = 1'b1;
    for (int c = 0; c < 200 && done_log.size() < 1; c++) step();
    toggle_mode = 1'b0;
    check("C_reads", xfer_total, 20);
    check("C_done_count", done_log.size(), 1);
    check("C_len", (done_log.size() > 0) ? done_log[0] : -1, 20);

    // Window closes after word 5 of a 12-word frame.
    clear_fifos();
    load(0, 1, 12);
    load(1, 1, 12);
    bias[0] = 64;
    bias[1] = 64;
    gt_r = 1'b1;
    do_reset(2);
    for (int c = 0; c < 200 && done_log.size() < 1; c++) begin
      step();
      if (xfer_total == 5) gt_r = 1'b0;
    end
    check("D_reads", xfer_total, 12);
    check("D_done_count", done_log.size(), 1);
    check("D_len", (done_log.size() > 0) ? done_log[0] : -1, 12);
    repeat (20) step();
    check("D_no_regrant", grant_log.size(), 1);
    check("D_idle_busy", int'(bus.busy), 0);
    gt_r = 1'b1;
    for (int c = 0; c < 20 && grant_log.size() < 2; c++) step();
    check("D_next_grant", grant_at(1), 1);
    for (int c = 0; c < 20 && xfer_total < 15; c++) step();
    check("D_reads_before_rst", xfer_total, 15);
    n0 = done_log.size();
    rst = 1'b1;
    step();
    check("D_rst_rd_en", int'(bus.q_rd_en), 0);
    rst = 1'b0;
    clear_fifos();
    repeat (10) step();
    check("D_no_done_after_rst", done_log.size(), n0);

    // Queues 0 and 3 continuously eligible.
    clear_fifos();
    load(0, 3, 4);
    load(3, 3, 4);
    bias[0] = 64;
    bias[3] = 64;
    do_reset(2);
    for (int c = 0; c < 200 && grant_log.size() < 3; c++) step();
    for (int i = 0; i < 3; i++) begin
`ifdef PON_SCHED_STRICT_PRIO_EN
      exp_e = 0;
`else
      exp_e = (i % 2 == 0) ? 0 : 3;
`endif
      check($sformatf("E_grant%0d", i), grant_at(i), exp_e);
    end

    // Randomized traffic, stalls and window toggling against the reference model.
    for (int ep = 0; ep < 8; ep++) begin
      clear_fifos();
      for (int i = 0; i < NUM_Q; i++) begin
        load(i, $urandom_range(0, 3), $urandom_range(1, 8));
        case ($urandom_range(0, 3))
          0:       bias[i] = 0;
          1:       bias[i] = 40;
          2:       bias[i] = 64;
          default: bias[i] = 200;
        endcase
      end
      gt_r = 1'b1;
      do_reset(2);
      rand_mode = 1'b1;
      for (int c = 0; c < 300; c++) begin
        gt_r = ($urandom_range(0, 7) != 0);
        step();
      end
      rand_mode = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
